// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage sitting directly in front of a unified, word-addressed memory
// with a one-cycle read latency. Every cycle it presents a word address.
// One cycle later it captures the word that the memory returns into a small
// skid FIFO. Decode drains the FIFO over a valid/ready handshake. A redirect
// loads a new PC and squashes everything older: the FIFO contents and the
// response that is in flight.
//
// Parameters:
//   RESET_PC   first word address fetched after reset
//   BUF_DEPTH  skid FIFO entries (2..4); 2 sustains one instruction per cycle
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   instruct_addr  word address to memory (sampled by memory on next edge)
//   instruct_val   memory read data, valid the cycle after the address
//   redirect       load redirect_addr as new PC and flush; highest priority
//   redirect_addr  redirect target word address
//   instr_ready    decode accepts the head word this cycle
//   instr_valid    head FIFO entry is valid
//   instr_out      head instruction word (0 when not valid)
//   instr_pc       word address of instr_out (0 when not valid)
//
// Optional build macro FETCH_PERF_EN adds two saturating counters:
//   perf_fetches   memory requests issued (redirect fetches included)
//   perf_bubbles   cycles with instr_valid low since reset release
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instruct_addr,
  input  logic [31:0] instruct_val,
  input  logic        redirect,
  input  logic [31:0] redirect_addr,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetches,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(BUF_DEPTH);
  localparam logic [CW:0]   DEPTH_EXT = (CW + 1)'(BUF_DEPTH);

  // fetch side
  logic [31:0] pc;
  logic        resp_pending;
  logic [31:0] resp_pc;

  // skid FIFO
  logic [31:0]   buf_data [BUF_DEPTH];
  logic [31:0]   buf_pc   [BUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        pop;
  logic        push;
  logic        issue;
  logic [CW:0] occupancy;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign instr_valid = (count != '0);
  assign instr_out   = instr_valid ? buf_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? buf_pc[rd_ptr]   : '0;

  assign pop  = instr_valid & instr_ready & ~redirect;
  // a redirect squashes the response that arrives in the same cycle
  assign push = resp_pending & ~redirect;

  // A redirect target is presented combinationally so that the memory
  // starts on it immediately. Otherwise the current PC is shown even when
  // no request is issued. That re-read is harmless because it is never
  // captured.
  assign instruct_addr = redirect ? redirect_addr : pc;

  // Only issue when the word will have a slot on arrival: words already
  // buffered plus the one in flight, less the word leaving this cycle.
  always_comb begin
    occupancy = {1'b0, count} + {{CW{1'b0}}, resp_pending} - {{CW{1'b0}}, pop};
    issue     = ~redirect & (occupancy < DEPTH_EXT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc           <= RESET_PC;
      resp_pending <= 1'b0;
      resp_pc      <= '0;
    end else if (redirect) begin
      pc           <= redirect_addr + 32'd1;
      resp_pending <= 1'b1;
      resp_pc      <= redirect_addr;
    end else if (issue) begin
      pc           <= pc + 32'd1;
      resp_pending <= 1'b1;
      resp_pc      <= pc;
    end else begin
      resp_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the read side is masked by instr_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr] <= instruct_val;
      buf_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetches <= '0;
      perf_bubbles <= '0;
    end else begin
      if ((issue || redirect) && (perf_fetches != 32'hFFFF_FFFF))
        perf_fetches <= perf_fetches + 32'd1;
      if (!instr_valid && (perf_bubbles != 32'hFFFF_FFFF))
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

  // the issue rule must make a push into a full FIFO impossible
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
    !(push && !pop && (count == FULL_CNT)));

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instruct_addr;
  logic [31:0] instruct_val = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = '0;
  logic        instr_ready = 1'b1;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetches;
  logic [31:0] perf_bubbles;
`endif

  int checks = 0;
  int errors = 0;
  int pops   = 0;

  // reference model: delivered stream is the contiguous word sequence
  // starting at the most recent reset/redirect target
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  instruction_fetch #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
    .clk(clk),
    .reset(reset),
    .instruct_addr(instruct_addr),
    .instruct_val(instruct_val),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .instr_ready(instr_ready),
    .instr_valid(instr_valid),
    .instr_out(instr_out),
    .instr_pc(instr_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetches(perf_fetches),
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a <= 32'd10) return 32'd5;
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  // one-cycle-latency memory
  always @(posedge clk) instruct_val <= mem_word(instruct_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic topup();
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd1;
    end
  endtask

  task automatic seed(input logic [31:0] a);
    exp_q.delete();
    gen_pc = a;
    topup();
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // monitor / scoreboard
  logic        hold = 1'b0;
  logic [31:0] hold_pc;
  logic [31:0] hold_out;
  logic [31:0] e;

  always @(negedge clk) begin
    if (!reset) begin
      hold = 1'b0;
      check("reset_valid", {31'd0, instr_valid}, 32'd0);
    end else begin
      if (hold) begin
        check("stall_valid", {31'd0, instr_valid}, 32'd1);
        check("stall_pc", instr_pc, hold_pc);
        check("stall_out", instr_out, hold_out);
      end
      if (instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got pc %h expected none", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("sb_pc", instr_pc, e);
          check("sb_out", instr_out, mem_word(e));
          pops++;
          topup();
        end
      end
      hold     = instr_valid && !instr_ready && !redirect;
      hold_pc  = instr_pc;
      hold_out = instr_out;
    end
  end

  int rst_cnt;
  int pops0;
  int r;

  initial begin
    seed(RESET_PC);
    repeat (3) cyc();
    settle();
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_instruct_addr", instruct_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    check("rst_perf_fetches", perf_fetches, 32'd0);
    check("rst_perf_bubbles", perf_bubbles, 32'd0);
`endif

    // release: first word two cycles later, then stall decode
    cyc(); seed(RESET_PC); reset = 1'b1; instr_ready = 1'b1;   // c0
    settle(); check("lat_c0_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); settle(); check("lat_c1_valid", {31'd0, instr_valid}, 32'd0);
    cyc(); instr_ready = 1'b0; settle();                        // c2
    check("lat_c2_valid", {31'd0, instr_valid}, 32'd1);
    check("lat_c2_pc", instr_pc, RESET_PC);
    check("lat_c2_out", instr_out, 32'd5);
`ifdef FETCH_PERF_EN
    check("perf_fetch_c2", perf_fetches, 32'd2);
    check("perf_bubble_c2", perf_bubbles, 32'd2);
`endif
    for (int i = 3; i <= 6; i++) begin
      cyc(); settle();
      check("stall_head_pc", instr_pc, RESET_PC);
      check("stall_addr_frozen", instruct_addr, RESET_PC + 32'd2);
    end
    cyc(); instr_ready = 1'b1; settle();                        // c7
    check("drain_pc0", instr_pc, RESET_PC);
    for (int i = 1; i <= 9; i++) begin
      cyc(); settle();
      check("drain_valid", {31'd0, instr_valid}, 32'd1);
      check("drain_pc", instr_pc, RESET_PC + 32'(i));
`ifdef FETCH_PERF_EN
      if (i == 1) check("perf_fetch_c8", perf_fetches, 32'd3);
`endif
    end

    // redirect while FIFO full
    cyc(); instr_ready = 1'b0;
    cyc();
    cyc(); redirect = 1'b1; redirect_addr = 32'h40; seed(32'h40); settle();
    check("redir_full_valid", {31'd0, instr_valid}, 32'd1);
    check("redir_addr_comb", instruct_addr, 32'h40);
    cyc(); redirect = 1'b0; instr_ready = 1'b1; settle();
    check("redir_bubble", {31'd0, instr_valid}, 32'd0);
    cyc(); settle();
    check("redir_target_valid", {31'd0, instr_valid}, 32'd1);
    check("redir_target_pc", instr_pc, 32'h40);

    // back-to-back redirects
    cyc(); redirect = 1'b1; redirect_addr = 32'h10; seed(32'h10);
    cyc(); redirect_addr = 32'h20; seed(32'h20);
    cyc(); redirect = 1'b0; settle();
    check("b2b_bubble", {31'd0, instr_valid}, 32'd0);
    cyc(); settle();
    check("b2b_pc", instr_pc, 32'h20);

    // PC wrap
    cyc(); redirect = 1'b1; redirect_addr = 32'hFFFF_FFFF; seed(32'hFFFF_FFFF);
    cyc(); redirect = 1'b0;
    cyc(); settle(); check("wrap_pc0", instr_pc, 32'hFFFF_FFFF);
    cyc(); settle(); check("wrap_pc1", instr_pc, 32'h0000_0000);
    cyc(); settle(); check("wrap_pc2", instr_pc, 32'h0000_0001);

    // reset mid-stream with a full FIFO
    cyc(); instr_ready = 1'b0;
    cyc();
    cyc(); reset = 1'b0; seed(RESET_PC); settle();
    check("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check("midrst_addr", instruct_addr, RESET_PC);
`ifdef FETCH_PERF_EN
    check("midrst_perf", perf_fetches, 32'd0);
`endif
    cyc();
    cyc(); reset = 1'b1; instr_ready = 1'b1;
    cyc();
    cyc(); settle();
    check("midrst_restart_valid", {31'd0, instr_valid}, 32'd1);
    check("midrst_restart_pc", instr_pc, RESET_PC);
`ifdef FETCH_PERF_EN
    check("midrst_perf_count", perf_fetches, 32'd2);
`endif

    // randomized phase
    pops0 = pops;
    rst_cnt = 0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (rst_cnt > 0) begin
        rst_cnt--;
        if (rst_cnt == 0) reset = 1'b1;
      end else begin
        instr_ready = ($urandom_range(0, 3) != 0);
        redirect = 1'b0;
        r = int'($urandom_range(0, 399));
        if (r == 0) begin
          reset = 1'b0;
          seed(RESET_PC);
          rst_cnt = int'($urandom_range(1, 3));
        end else if (r < 25) begin
          redirect = 1'b1;
          if (r < 8) redirect_addr = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
          else       redirect_addr = $urandom;
          seed(redirect_addr);
        end
      end
    end
    cyc(); redirect = 1'b0; reset = 1'b1; instr_ready = 1'b1;
    cyc();
    check("random_progress", {31'd0, (pops - pops0) > 1000}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
